// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aes_pkg
// Description : Shared AES constants, GF(2^8) helper functions and the
//               MixColumns engine state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

    localparam int         AES_STATE_W = 128;
    localparam int         AES_COL_W   = 32;
    localparam logic [7:0] AES_POLY    = 8'h1B;

    // Engine control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } mc_state_t;

    // Multiply by x modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return xtime(a);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    // 9 = 8 + 1
    function automatic logic [7:0] gf_mul9(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    // 0B = 8 + 2 + 1
    function automatic logic [7:0] gf_mulb(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction

    // 0D = 8 + 4 + 1
    function automatic logic [7:0] gf_muld(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction

    // 0E = 8 + 4 + 2
    function automatic logic [7:0] gf_mule(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mix_column_unit.sv
`default_nettype none
// ============================================================================
// Module      : mix_column_unit
// Description : Combinational transform of one 32-bit AES column, forward
//               MixColumns or InvMixColumns selected by 'inverse'.
//               Byte s0 is the most significant byte of the column.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_column_unit
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_in,
    input  logic                 inverse,
    output logic [AES_COL_W-1:0] col_out
);

    logic [7:0] w_s0, w_s1, w_s2, w_s3;
    logic [AES_COL_W-1:0] w_fwd, w_inv;

    assign {w_s0, w_s1, w_s2, w_s3} = col_in;

    // Both matrix products are formed; direction picks one
    always_comb begin
        w_fwd = {
            gf_mul2(w_s0) ^ gf_mul3(w_s1) ^ w_s2          ^ w_s3,
            w_s0          ^ gf_mul2(w_s1) ^ gf_mul3(w_s2) ^ w_s3,
            w_s0          ^ w_s1          ^ gf_mul2(w_s2) ^ gf_mul3(w_s3),
            gf_mul3(w_s0) ^ w_s1          ^ w_s2          ^ gf_mul2(w_s3)
        };
        w_inv = {
            gf_mule(w_s0) ^ gf_mulb(w_s1) ^ gf_muld(w_s2) ^ gf_mul9(w_s3),
            gf_mul9(w_s0) ^ gf_mule(w_s1) ^ gf_mulb(w_s2) ^ gf_muld(w_s3),
            gf_muld(w_s0) ^ gf_mul9(w_s1) ^ gf_mule(w_s2) ^ gf_mulb(w_s3),
            gf_mulb(w_s0) ^ gf_muld(w_s1) ^ gf_mul9(w_s2) ^ gf_mule(w_s3)
        };
        col_out = inverse ? w_inv : w_fwd;
    end

endmodule
`default_nettype wire

// File: rtl/mix_columns_engine.sv
`default_nettype none
// ============================================================================
// Module      : mix_columns_engine
// Description : Iterative, handshaked AES MixColumns / InvMixColumns engine.
//               Transforms COLS_PER_CYCLE columns per clock and presents the
//               complete mixed state in HOLD until the consumer takes it.
// Config      : MIXCOL_PIPE_EN - adds a register stage between the column
//               datapath and the result register (latency NCYC+1).
// Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_engine
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inverse,
    input  logic [AES_STATE_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_inverse,
    output logic [AES_STATE_W-1:0] out_data,
    output logic                   busy
);

    localparam int         NCYC     = 4 / COLS_PER_CYCLE;
    localparam int         GRP_W    = COLS_PER_CYCLE * AES_COL_W;
    localparam logic [1:0] LAST_GRP = 2'(NCYC - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    mc_state_t              r_state;
    mc_state_t              w_state_next;
    logic [1:0]             r_col_idx;
    logic [AES_STATE_W-1:0] r_src;
    logic [AES_STATE_W-1:0] r_work;
    logic [AES_STATE_W-1:0] r_out_data;
    logic [AES_STATE_W-1:0] w_merged;
    logic                   r_inverse;
    logic                   r_out_inverse;
    logic [GRP_W-1:0]       w_grp_out;
    logic [GRP_W-1:0]       w_wr_data;
    logic [1:0]             w_wr_idx;
    logic                   w_accept;
    logic                   w_issue;
    logic                   w_wr_en;
    logic                   w_wr_last;

    assign w_accept    = (r_state == IDLE) && in_valid;
    assign in_ready    = (r_state == IDLE);
    assign out_valid   = (r_state == HOLD);
    assign busy        = (r_state != IDLE);
    assign out_data    = r_out_data;
    assign out_inverse = r_out_inverse;

    // Column datapath: one unit per column of the current group
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        logic [1:0]           w_col_num;
        logic [6:0]           w_base;
        logic [AES_COL_W-1:0] w_col_in;
        logic [AES_COL_W-1:0] w_col_out;

        // Column c occupies bits [127-32c -: 32]; 127-32c == {~c, 5'h1F}
        assign w_col_num = 2'(r_col_idx * 2'(COLS_PER_CYCLE)) + 2'(k);
        assign w_base    = {~w_col_num, 5'h1F};
        assign w_col_in  = r_src[w_base -: AES_COL_W];

        mix_column_unit u_unit (
            .col_in  (w_col_in),
            .inverse (r_inverse),
            .col_out (w_col_out)
        );

        assign w_grp_out[GRP_W-1-AES_COL_W*k -: AES_COL_W] = w_col_out;
    end

`ifdef MIXCOL_PIPE_EN
    logic             r_issue_done;
    logic             r_pipe_vld;
    logic [GRP_W-1:0] r_pipe_data;
    logic [1:0]       r_pipe_idx;

    // Groups are issued until the last one has entered the stage register
    assign w_issue = (r_state == RUN) && !r_issue_done;

    // Stage register between column datapath and result register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_issue_done <= 1'b0;
            r_pipe_vld   <= 1'b0;
            r_pipe_data  <= '0;
            r_pipe_idx   <= '0;
        end else begin
            r_pipe_vld  <= w_issue;
            r_pipe_data <= w_grp_out;
            r_pipe_idx  <= r_col_idx;
            if (w_accept) begin
                r_issue_done <= 1'b0;
            end else if (w_issue && (r_col_idx == LAST_GRP)) begin
                r_issue_done <= 1'b1;
            end
        end
    end

    assign w_wr_en   = (r_state == RUN) && r_pipe_vld;
    assign w_wr_idx  = r_pipe_idx;
    assign w_wr_data = r_pipe_data;
`else
    assign w_issue   = (r_state == RUN);
    assign w_wr_en   = w_issue;
    assign w_wr_idx  = r_col_idx;
    assign w_wr_data = w_grp_out;
`endif

    assign w_wr_last = w_wr_en && (w_wr_idx == LAST_GRP);

    // Overlay the group being written onto the partially built result
    always_comb begin
        w_merged = r_work;
        for (int c = 0; c < 4; c++) begin
            if ((c / COLS_PER_CYCLE) == int'(w_wr_idx)) begin
                w_merged[AES_STATE_W-1-AES_COL_W*c -: AES_COL_W] =
                    w_wr_data[GRP_W-1-AES_COL_W*(c % COLS_PER_CYCLE) -: AES_COL_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_wr_last) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Column group counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_idx <= '0;
        end else if (w_accept) begin
            r_col_idx <= '0;
        end else if (w_issue) begin
            r_col_idx <= r_col_idx + 2'd1;
        end
    end

    // Capture the source state and direction on accept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_src     <= '0;
            r_inverse <= 1'b0;
        end else if (w_accept) begin
            r_src     <= in_data;
            r_inverse <= in_inverse;
        end
    end

    // Build the result; the output register only changes on the final group
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work        <= '0;
            r_out_data    <= '0;
            r_out_inverse <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_work <= w_merged;
            end
            if (w_wr_last) begin
                r_out_data    <= w_merged;
                r_out_inverse <= r_inverse;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_mix_columns_engine
// Description : Self-checking bench for mix_columns_engine. Three instances
//               (COLS_PER_CYCLE = 1, 2, 4) are checked every cycle against a
//               generic GF(2^8) matrix-multiply model.
// Config      : MIXCOL_PIPE_EN - expected latency grows by one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_columns_engine;

    localparam int NDUT = 3;
`ifdef MIXCOL_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    localparam logic [127:0] V1     = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V3     = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V3_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid    [NDUT];
    logic         in_ready    [NDUT];
    logic         in_inverse  [NDUT];
    logic [127:0] in_data     [NDUT];
    logic         out_valid   [NDUT];
    logic         out_ready   [NDUT];
    logic         out_inverse [NDUT];
    logic [127:0] out_data    [NDUT];
    logic         busy        [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mix_columns_engine #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .in_valid    (in_valid[g]),
            .in_ready    (in_ready[g]),
            .in_inverse  (in_inverse[g]),
            .in_data     (in_data[g]),
            .out_valid   (out_valid[g]),
            .out_ready   (out_ready[g]),
            .out_inverse (out_inverse[g]),
            .out_data    (out_data[g]),
            .busy        (busy[g])
        );
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Scoreboard state per instance
    bit           pending    [NDUT];
    logic [127:0] exp_d      [NDUT];
    logic         exp_i      [NDUT];
    int           acc_cyc    [NDUT];
    logic [127:0] last_d     [NDUT];
    logic         last_i     [NDUT];
    bit           prev_pop   [NDUT];
    bit           prev_stall [NDUT];
    bit           prev_valid [NDUT];
    bit           post_rst   [NDUT];
    bit           fired      [NDUT];
    int           n_done     [NDUT];

    task automatic check(input int dut, input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL dut%0d %s: actual %h required %h", dut, name, act, req);
        end
    endtask

    // Generic GF(2^8) product: shift-and-add, then reduce by 0x11B
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ (16'(a) << k);
        end
        for (int k = 14; k >= 8; k--) begin
            if (p[k]) p = p ^ (16'h011B << (k - 8));
        end
        return p[7:0];
    endfunction

    // Circulant matrix times each column; row r is the first row rotated by r
    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [7:0]   row0 [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inv) begin
            row0[0] = 8'h0E; row0[1] = 8'h0B; row0[2] = 8'h0D; row0[3] = 8'h09;
        end else begin
            row0[0] = 8'h02; row0[1] = 8'h03; row0[2] = 8'h01; row0[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int rr = 0; rr < 4; rr++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(row0[(j - rr + 4) % 4], d[127 - 32*c - 8*j -: 8]);
                end
                r[127 - 32*c - 8*rr -: 8] = acc;
            end
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare process for all instances
    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            fired[i] = 1'b0;
            if (rst) begin
                pending[i]    = 1'b0;
                post_rst[i]   = 1'b1;
                last_d[i]     = '0;
                last_i[i]     = 1'b0;
                prev_pop[i]   = 1'b0;
                prev_stall[i] = 1'b0;
                prev_valid[i] = 1'b0;
            end else begin
                if (post_rst[i]) begin
                    check(i, !out_valid[i], "reset_out_valid", 128'(out_valid[i]), 128'd0);
                    check(i, !busy[i], "reset_busy", 128'(busy[i]), 128'd0);
                    check(i, in_ready[i], "reset_in_ready", 128'(in_ready[i]), 128'd1);
                    check(i, out_data[i] == '0, "reset_out_data", out_data[i], 128'd0);
                    check(i, !out_inverse[i], "reset_out_inverse", 128'(out_inverse[i]), 128'd0);
                    post_rst[i] = 1'b0;
                end
                check(i, busy[i] == !in_ready[i], "busy_vs_in_ready", 128'(busy[i]), 128'(!in_ready[i]));
                if (prev_pop[i]) begin
                    check(i, !out_valid[i] && in_ready[i], "after_transfer",
                          128'({out_valid[i], in_ready[i]}), 128'b01);
                end
                if (prev_stall[i]) begin
                    check(i, out_valid[i], "hold_persists", 128'(out_valid[i]), 128'd1);
                end
                if (out_valid[i]) begin
                    check(i, pending[i], "unexpected_out_valid", 128'(out_valid[i]), 128'd0);
                    if (!prev_valid[i]) begin
                        check(i, (cyc - acc_cyc[i]) == ((4 >> i) + PIPE), "latency",
                              128'(cyc - acc_cyc[i]), 128'((4 >> i) + PIPE));
                    end
                    check(i, out_data[i] == exp_d[i], "out_data", out_data[i], exp_d[i]);
                    check(i, out_inverse[i] == exp_i[i], "out_inverse", 128'(out_inverse[i]), 128'(exp_i[i]));
                    check(i, !in_ready[i], "in_ready_in_hold", 128'(in_ready[i]), 128'd0);
                    last_d[i] = out_data[i];
                    last_i[i] = out_inverse[i];
                end else begin
                    check(i, out_data[i] == last_d[i], "out_data_held", out_data[i], last_d[i]);
                    check(i, out_inverse[i] == last_i[i], "out_inverse_held",
                          128'(out_inverse[i]), 128'(last_i[i]));
                    if (pending[i]) begin
                        check(i, !in_ready[i] && busy[i], "run_busy",
                              128'({in_ready[i], busy[i]}), 128'b01);
                    end
                end
                prev_pop[i]   = out_valid[i] && out_ready[i];
                prev_stall[i] = out_valid[i] && !out_ready[i];
                prev_valid[i] = out_valid[i];
                if (out_valid[i] && out_ready[i]) begin
                    pending[i] = 1'b0;
                    n_done[i]++;
                end
                if (in_valid[i] && in_ready[i]) begin
                    check(i, !pending[i], "accept_while_pending", 128'(pending[i]), 128'd0);
                    pending[i] = 1'b1;
                    exp_d[i]   = model(in_data[i], in_inverse[i]);
                    exp_i[i]   = in_inverse[i];
                    acc_cyc[i] = cyc + 1;
                    fired[i]   = 1'b1;
                end
            end
        end
    end

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one state to every instance and wait until each has taken it
    task automatic send_all(input logic [127:0] d, input logic inv);
        int t;
        bit waiting;
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]   = 1'b1;
            in_data[i]    = d;
            in_inverse[i] = inv;
        end
        t = 0;
        do begin
            @(posedge clk); #1;
            waiting = 1'b0;
            for (int i = 0; i < NDUT; i++) begin
                if (fired[i]) in_valid[i] = 1'b0;
                waiting |= in_valid[i];
            end
            t++;
        end while (waiting && t < 50);
        check(-1, !waiting, "accept_timeout", 128'(waiting), 128'd0);
        for (int i = 0; i < NDUT; i++) in_valid[i] = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int t;
        bit any;
        t = 0;
        do begin
            @(posedge clk); #1;
            any = 1'b0;
            for (int i = 0; i < NDUT; i++) any |= pending[i];
            t++;
        end while (any && t < budget);
        check(-1, !any, "completion_timeout", 128'(any), 128'd0);
    endtask

    task automatic random_phase(input int ncyc, input int vpct, input int rpct);
        repeat (ncyc) begin
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++) begin
                if (!in_valid[i] || fired[i] || $urandom_range(0, 3) == 0) begin
                    in_valid[i]   = ($urandom_range(0, 99) < vpct);
                    in_data[i]    = rand128();
                    in_inverse[i] = 1'($urandom_range(0, 1));
                end
                out_ready[i] = ($urandom_range(0, 99) < rpct);
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        wait_idle(64);
    endtask

    initial begin
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]   = 1'b0;
            in_inverse[i] = 1'b0;
            in_data[i]    = '0;
            out_ready[i]  = 1'b1;
            n_done[i]     = 0;
        end

        // Pin the reference model to hand-computed values
        check(-1, gmul(8'h57, 8'h83) == 8'hC1, "model_gmul", 128'(gmul(8'h57, 8'h83)), 128'hC1);
        check(-1, model(V1, 1'b0) == V1_OUT, "model_fwd_v1", model(V1, 1'b0), V1_OUT);
        check(-1, model(V1_OUT, 1'b1) == V1, "model_inv_v1", model(V1_OUT, 1'b1), V1);
        check(-1, model(V3, 1'b0) == V3_OUT, "model_fwd_v3", model(V3, 1'b0), V3_OUT);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Known-answer transactions on every instance
        send_all(V1, 1'b0);
        wait_idle(32);
        for (int i = 0; i < NDUT; i++) check(i, last_d[i] == V1_OUT, "kat_fwd_v1", last_d[i], V1_OUT);
        send_all(V1_OUT, 1'b1);
        wait_idle(32);
        for (int i = 0; i < NDUT; i++) begin
            check(i, last_d[i] == V1, "kat_inv_v1", last_d[i], V1);
            check(i, last_i[i] == 1'b1, "kat_inv_dir", 128'(last_i[i]), 128'd1);
        end
        send_all(V3, 1'b0);
        wait_idle(32);
        for (int i = 0; i < NDUT; i++) check(i, last_d[i] == V3_OUT, "kat_fwd_v3", last_d[i], V3_OUT);

        // Backpressure: stall in HOLD while the input side churns
        for (int i = 0; i < NDUT; i++) out_ready[i] = 1'b0;
        send_all(rand128(), 1'b0);
        repeat (4 + PIPE) @(posedge clk);
        repeat (10) begin
            @(posedge clk); #1;
            for (int i = 0; i < NDUT; i++) begin
                in_valid[i]   = 1'($urandom_range(0, 1));
                in_data[i]    = rand128();
                in_inverse[i] = 1'($urandom_range(0, 1));
            end
        end
        for (int i = 0; i < NDUT; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        wait_idle(32);

        // Reset while the single-column instance is two groups in
        send_all(rand128(), 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_all(V3, 1'b0);
        wait_idle(32);
        for (int i = 0; i < NDUT; i++) check(i, last_d[i] == V3_OUT, "post_reset_kat", last_d[i], V3_OUT);

        // Random traffic with stalls, then back-to-back streaming
        random_phase(3000, 70, 60);
        random_phase(7500, 100, 100);
        check(0, n_done[0] >= 1000, "stream_count", 128'(n_done[0]), 128'd1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
